// File: rtl/dcache_req_arbiter_pkg.sv
// ============================================================================
//  Module   : dcache_req_arbiter_pkg
//  Purpose  : Shared widths, state encodings and request-type encodings for
//             the DCache stage-1 request arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef InstAddrBus
`define InstAddrBus 31:0
`endif

package dcache_req_arbiter_pkg;

  // Default widths; the address width tracks the instruction address bus.
  localparam int DCACHE_ADDR_W     = 32;
  localparam int DCACHE_DATA_W     = 32;
  localparam int DCACHE_STARVE_MAX = 4;

  typedef logic [`InstAddrBus] inst_addr_t;

  // Issue-register FSM encodings.
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  // Request-type encodings carried on S1IsStore.
  localparam logic [0:0] REQ_LOAD  = 1'b0;
  localparam logic [0:0] REQ_STORE = 1'b1;

  // Width of a counter that must be able to hold the value max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dcache_req_arbiter_if.sv
// ============================================================================
//  Module   : dcache_req_arbiter_if
//  Purpose  : Bundles the control, AGU1 load, AGU2 store and stage-1 issue
//             signals around the DCache request arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dcache_req_arbiter_if
  import dcache_req_arbiter_pkg::*;
#(
  parameter int ADDR_W = DCACHE_ADDR_W,
  parameter int DATA_W = DCACHE_DATA_W
) ();

  // Pipeline control
  logic                DcacheStop;
  logic                DcacheFlash;
  logic                DcacheReq;
  // AGU1 load requester
  logic                LoadAble;
  logic                LoadReq;
  logic [ADDR_W-1:0]   LoadPhyAddr;
  // AGU2 store requester
  logic                StoreAble;
  logic                StoreReq;
  logic [ADDR_W-1:0]   StorePhyAddr;
  logic [DATA_W-1:0]   StoreData;
  logic [DATA_W/8-1:0] StoreMask;
  // Stage-1 issue register
  logic                S1Valid;
  logic                S1IsStore;
  logic [ADDR_W-1:0]   S1Addr;
  logic [DATA_W-1:0]   S1Data;
  logic [DATA_W/8-1:0] S1Mask;
  logic                S1Ready;

  // Arbiter side.
  modport slave (
    input  DcacheStop, DcacheFlash,
    input  LoadAble, LoadPhyAddr,
    input  StoreAble, StorePhyAddr, StoreData, StoreMask,
    input  S1Ready,
    output DcacheReq, LoadReq, StoreReq,
    output S1Valid, S1IsStore, S1Addr, S1Data, S1Mask
  );

  // Requester / control / stage-1 side.
  modport master (
    output DcacheStop, DcacheFlash,
    output LoadAble, LoadPhyAddr,
    output StoreAble, StorePhyAddr, StoreData, StoreMask,
    output S1Ready,
    input  DcacheReq, LoadReq, StoreReq,
    input  S1Valid, S1IsStore, S1Addr, S1Data, S1Mask
  );

endinterface

`default_nettype wire

// File: rtl/dcache_req_arbiter_grant.sv
// ============================================================================
//  Module   : dcache_arb_grant
//  Purpose  : Combinational grant decision between the load and store
//             requesters: single-requester pass-through, same-word store
//             first, starvation-forced store, otherwise load priority.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dcache_arb_grant
  import dcache_req_arbiter_pkg::*;
#(
  parameter int ADDR_W     = DCACHE_ADDR_W,
  parameter int STARVE_MAX = DCACHE_STARVE_MAX,
  parameter int CNT_W      = cnt_width(DCACHE_STARVE_MAX)
) (
  input  logic              can_accept,
  input  logic              load_able,
  input  logic              store_able,
  input  logic [ADDR_W-3:0] load_word,
  input  logic [ADDR_W-3:0] store_word,
  input  logic [CNT_W-1:0]  starve_cnt,
  output logic              grant_load,
  output logic              grant_store
);

  logic w_same_word;
  logic w_starved;

  assign w_same_word = (load_word == store_word);
  assign w_starved   = (starve_cnt == CNT_W'(STARVE_MAX));

  // Pick at most one winner; nothing is granted when the issue slot is busy.
  always_comb begin
    grant_load  = 1'b0;
    grant_store = 1'b0;
    if (can_accept) begin
      if (load_able && !store_able) begin
        grant_load = 1'b1;
      end else if (store_able && !load_able) begin
        grant_store = 1'b1;
      end else if (load_able && store_able) begin
        // Older store to the same word must reach the cache before the load.
        if (w_same_word || w_starved) begin
          grant_store = 1'b1;
        end else begin
          grant_load = 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/dcache_req_arbiter.sv
// ============================================================================
//  Module   : dcache_req_arbiter
//  Purpose  : Single-entry arbiter and issue register in front of DCache
//             stage 1, shared by the AGU1 load and AGU2 store requesters.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dcache_req_arbiter
  import dcache_req_arbiter_pkg::*;
#(
  parameter int ADDR_W     = DCACHE_ADDR_W,
  parameter int DATA_W     = DCACHE_DATA_W,
  parameter int STARVE_MAX = DCACHE_STARVE_MAX
) (
  input  logic               Clk,
  input  logic               Rest,
  dcache_req_arbiter_if.slave bus
);

  localparam int CNT_W = cnt_width(STARVE_MAX);

  logic [0:0]          r_state;
  logic [0:0]          w_state_nxt;
  logic [CNT_W-1:0]    r_starve;
  logic                r_is_store;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data;
  logic [DATA_W/8-1:0] r_mask;

  logic w_can_accept;
  logic w_grant_load;
  logic w_grant_store;
  logic w_grant_any;

  // Slot is free when empty or being drained this cycle; stop/flush and an
  // asserted reset block every handshake.
  assign w_can_accept = Rest && !bus.DcacheStop && !bus.DcacheFlash &&
                        ((r_state == ST_EMPTY) || bus.S1Ready);
  assign w_grant_any  = w_grant_load || w_grant_store;

  dcache_arb_grant #(
    .ADDR_W     (ADDR_W),
    .STARVE_MAX (STARVE_MAX),
    .CNT_W      (CNT_W)
  ) u_grant (
    .can_accept  (w_can_accept),
    .load_able   (bus.LoadAble),
    .store_able  (bus.StoreAble),
    .load_word   (bus.LoadPhyAddr[ADDR_W-1:2]),
    .store_word  (bus.StorePhyAddr[ADDR_W-1:2]),
    .starve_cnt  (r_starve),
    .grant_load  (w_grant_load),
    .grant_store (w_grant_store)
  );

  // Issue-register occupancy state.
  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Flush empties the slot, stop freezes it, otherwise fill on grant or
  // drain when stage 1 consumes without a replacement.
  always_comb begin
    w_state_nxt = r_state;
    if (bus.DcacheFlash) begin
      w_state_nxt = ST_EMPTY;
    end else if (!bus.DcacheStop) begin
      if (w_grant_any) begin
        w_state_nxt = ST_FULL;
      end else if ((r_state == ST_FULL) && bus.S1Ready) begin
        w_state_nxt = ST_EMPTY;
      end
    end
  end

  // Handshake, busy and issue-register outputs.
  always_comb begin
    bus.LoadReq   = w_grant_load;
    bus.StoreReq  = w_grant_store;
    bus.S1Valid   = (r_state == ST_FULL);
    bus.S1IsStore = r_is_store;
    bus.S1Addr    = r_addr;
    bus.S1Data    = r_data;
    bus.S1Mask    = r_mask;
    bus.DcacheReq = (r_state == ST_FULL) || bus.LoadAble || bus.StoreAble;
  end

  // Payload of the issue register; only written on a completed handshake.
  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      r_is_store <= REQ_LOAD;
      r_addr     <= '0;
      r_data     <= '0;
      r_mask     <= '0;
    end else if (w_grant_store) begin
      r_is_store <= REQ_STORE;
      r_addr     <= bus.StorePhyAddr;
      r_data     <= bus.StoreData;
      r_mask     <= bus.StoreMask;
    end else if (w_grant_load) begin
      r_is_store <= REQ_LOAD;
      r_addr     <= bus.LoadPhyAddr;
      r_data     <= '0;
      r_mask     <= '0;
    end
  end

  // Count loads that beat a waiting store; any store grant or flush clears it.
  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      r_starve <= '0;
    end else if (bus.DcacheFlash || w_grant_store) begin
      r_starve <= '0;
    end else if (w_grant_load && bus.StoreAble &&
                 (r_starve != CNT_W'(STARVE_MAX))) begin
      r_starve <= r_starve + 1'b1;
    end
  end

endmodule

`default_nettype wire
